// File: rtl/approx_add_pipe.sv
// Two-stage approximate adder: OR-approximated low K bits with a carry guess into
// an exact upper add, plus error statistics measured against the exact sum.
module approx_add_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned K      = 4,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH:0]    sum,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] err_cnt,
    output logic [STAT_W-1:0] err_acc,
    output logic [WIDTH:0]    err_max
);

    localparam int unsigned HI_W  = WIDTH - K;
    localparam int unsigned ACC_W = ((STAT_W > WIDTH + 1) ? STAT_W : WIDTH + 1) + 1;
    localparam logic [ACC_W-1:0] STAT_MAX = ACC_W'({STAT_W{1'b1}});

    logic              s1_valid;
    logic [K-1:0]      s1_lo;
    logic              s1_cin;
    logic [HI_W-1:0]   s1_a_hi;
    logic [HI_W-1:0]   s1_b_hi;
    logic              s1_mode;
    logic [WIDTH:0]    s1_exact;

    logic              s2_mode;
    logic [WIDTH:0]    s2_exact;

    logic              s2_adv_c;
    logic [HI_W:0]     hi_sum_c;
    logic [WIDTH:0]    approx_c;
    logic              upd_c;
    logic [WIDTH:0]    err_c;
    logic [ACC_W-1:0]  acc_sum_c;

    // Output stage drains when empty or accepted; S1 accepts when it can move on.
    assign s2_adv_c = !out_valid || out_ready;
    assign in_ready = s2_adv_c || !s1_valid;

    assign hi_sum_c = (HI_W+1)'(s1_a_hi) + (HI_W+1)'(s1_b_hi) + (HI_W+1)'(s1_cin);
    assign approx_c = {hi_sum_c, s1_lo};

    // Approximate results can overshoot the exact sum, so the error is absolute.
    assign upd_c     = out_valid && out_ready && !s2_mode;
    assign err_c     = (s2_exact >= sum) ? (s2_exact - sum) : (sum - s2_exact);
    assign acc_sum_c = ACC_W'(err_acc) + ACC_W'(err_c);

    // Stage 1: low OR, carry guess, split upper operands and exact reference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_lo    <= '0;
            s1_cin   <= 1'b0;
            s1_a_hi  <= '0;
            s1_b_hi  <= '0;
            s1_mode  <= 1'b0;
            s1_exact <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo    <= a[K-1:0] | b[K-1:0];
                s1_cin   <= a[K-1] & b[K-1];
                s1_a_hi  <= a[WIDTH-1:K];
                s1_b_hi  <= b[WIDTH-1:K];
                s1_mode  <= mode;
                s1_exact <= (WIDTH+1)'(a) + (WIDTH+1)'(b);
            end
        end
    end

    // Stage 2: upper add and result select; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            s2_exact  <= '0;
            s2_mode   <= 1'b0;
        end else if (s2_adv_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum      <= s1_mode ? s1_exact : approx_c;
                s2_exact <= s1_exact;
                s2_mode  <= s1_mode;
            end
        end
    end

    // Error statistics, updated on approximate-mode handshakes; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_acc <= '0;
            err_max <= '0;
        end else if (stat_clr) begin
            err_cnt <= '0;
            err_acc <= '0;
            err_max <= '0;
        end else if (upd_c) begin
            if ((err_c != '0) && (err_cnt != {STAT_W{1'b1}})) begin
                err_cnt <= err_cnt + STAT_W'(1);
            end
            err_acc <= (acc_sum_c > STAT_MAX) ? {STAT_W{1'b1}} : acc_sum_c[STAT_W-1:0];
            if (err_c > err_max) begin
                err_max <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Scoreboard bench for approx_add_pipe: directed cases, reset abort, saturation
// on a narrow-statistics instance, and a long random stream with backpressure.
module tb_approx_add_pipe;

    localparam int unsigned W  = 8;
    localparam int unsigned KB = 4;

    typedef struct {
        int  s;
        int  ex;
        bit  m;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   sum;
    logic         stat_clr;
    logic [15:0]  err_cnt;
    logic [15:0]  err_acc;
    logic [W:0]   err_max;

    logic         x_in_ready;
    logic         x_out_valid;
    logic [W:0]   x_sum;
    logic [3:0]   x_err_cnt;
    logic [3:0]   x_err_acc;
    logic [W:0]   x_err_max;

    logic rand_bp, or_rand, or_force;
    logic rand_clr, clr_rand, clr_force;
    assign out_ready = rand_bp  ? or_rand  : or_force;
    assign stat_clr  = rand_clr ? clr_rand : clr_force;

    int n_vec = 0;
    int n_err = 0;
    exp_t q[$];
    int m_cnt16, m_acc16, m_cnt4, m_acc4, m_max;
    bit saw_in_ready_low;

    approx_add_pipe #(.WIDTH(W), .K(KB), .STAT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .stat_clr(stat_clr), .err_cnt(err_cnt), .err_acc(err_acc),
        .err_max(err_max)
    );

    approx_add_pipe #(.WIDTH(W), .K(KB), .STAT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready),
        .a(a), .b(b), .mode(mode), .out_valid(x_out_valid), .out_ready(out_ready),
        .sum(x_sum), .stat_clr(stat_clr), .err_cnt(x_err_cnt), .err_acc(x_err_acc),
        .err_max(x_err_max)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Reference: low bits are a|b, carry into the upper half guessed from bit K-1.
    function automatic int ref_approx(input int x, input int y);
        int lo  = (x | y) % (1 << KB);
        int cin = ((x >> (KB - 1)) & 1) * ((y >> (KB - 1)) & 1);
        int hi  = (x >> KB) + (y >> KB) + cin;
        return hi * (1 << KB) + lo;
    endfunction

    // Monitor and scoreboard, sampling on the falling edge.
    initial begin
        exp_t e;
        bit hs;
        int err;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                m_cnt16 = 0; m_acc16 = 0; m_cnt4 = 0; m_acc4 = 0; m_max = 0;
                chk("rst_out_valid", longint'(out_valid), 0);
                chk("rst_sum", longint'(sum), 0);
                chk("rst_in_ready", longint'(in_ready), 1);
                chk("rst_err_cnt", longint'(err_cnt), 0);
            end else begin
                if (!in_ready) saw_in_ready_low = 1'b1;
                chk("in_ready", longint'(in_ready), (q.size() == 2 && !out_ready) ? 0 : 1);
                chk("sat_in_ready", longint'(x_in_ready), longint'(in_ready));
                if (out_valid) begin
                    if (q.size() == 0) chk("spurious_out_valid", 1, 0);
                    else chk("sum", longint'(sum), longint'(q[0].s));
                end
                chk("err_cnt", longint'(err_cnt), longint'(m_cnt16));
                chk("err_acc", longint'(err_acc), longint'(m_acc16));
                chk("err_max", longint'(err_max), longint'(m_max));
                chk("sat_err_cnt", longint'(x_err_cnt), longint'(m_cnt4));
                chk("sat_err_acc", longint'(x_err_acc), longint'(m_acc4));
                hs = out_valid && out_ready && (q.size() > 0);
                if (hs) e = q.pop_front();
                if (stat_clr) begin
                    m_cnt16 = 0; m_acc16 = 0; m_cnt4 = 0; m_acc4 = 0; m_max = 0;
                end else if (hs && !e.m) begin
                    err = (e.ex > e.s) ? e.ex - e.s : e.s - e.ex;
                    if (err != 0) begin
                        m_cnt16 = sat(m_cnt16 + 1, 16);
                        m_cnt4  = sat(m_cnt4 + 1, 4);
                    end
                    m_acc16 = sat(m_acc16 + err, 16);
                    m_acc4  = sat(m_acc4 + err, 4);
                    if (err > m_max) m_max = err;
                end
                if (in_valid && in_ready) begin
                    e.ex = int'(a) + int'(b);
                    e.m  = mode;
                    e.s  = mode ? e.ex : ref_approx(int'(a), int'(b));
                    q.push_back(e);
                end
            end
        end
    end

    // Random backpressure and occasional statistics clears.
    initial begin
        or_rand = 1'b1;
        clr_rand = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            or_rand  = ($urandom_range(3) != 0);
            clr_rand = ($urandom_range(499) == 0);
        end
    end

    task automatic send(input int ta, input int tb, input bit tm);
        logic acc;
        int waited = 0;
        in_valid = 1'b1;
        a = W'(ta);
        b = W'(tb);
        mode = tm;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 1000) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (q.size() != 0 && waited < 2000) begin
            cycles(1);
            waited++;
        end
        chk("drain_empty", longint'(q.size()), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0;
        rand_bp = 1'b0; or_force = 1'b1; rand_clr = 1'b0; clr_force = 1'b0;
        saw_in_ready_low = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);

        // Latency and first approximate case.
        send(8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        chk("latency_not_early", longint'(out_valid), 0);
        @(negedge clk);
        chk("latency_valid", longint'(out_valid), 1);
        chk("first_sum", longint'(sum), 32'h00F);
        @(posedge clk); #1;
        cycles(1);
        chk("first_err_cnt", longint'(err_cnt), 1);
        chk("first_err_acc", longint'(err_acc), 1);
        chk("first_err_max", longint'(err_max), 1);

        // Approximation overshoot, then an exact transaction.
        send(8'h08, 8'h08, 1'b0);
        send(8'hFF, 8'h01, 1'b1);
        drain();
        cycles(1);
        chk("ovr_err_max", longint'(err_max), 8);
        chk("ovr_err_acc", longint'(err_acc), 9);
        chk("ovr_err_cnt", longint'(err_cnt), 2);

        // Back-to-back stream with a three-cycle downstream stall.
        fork
            begin
                send(8'h12, 8'h34, 1'b0);
                send(8'h9A, 8'h77, 1'b0);
                send(8'hF0, 8'h0F, 1'b1);
                send(8'h5C, 8'hAB, 1'b0);
            end
            begin
                cycles(2);
                or_force = 1'b0;
                cycles(3);
                or_force = 1'b1;
            end
        join
        drain();
        chk("stall_in_ready_fell", longint'(saw_in_ready_low), 1);

        // Saturation on the narrow-statistics instance, then a clear on a handshake.
        for (int i = 0; i < 20; i++) send(8'h08, 8'h08, 1'b0);
        drain();
        cycles(1);
        chk("sat_cnt_f", longint'(x_err_cnt), 15);
        chk("sat_acc_f", longint'(x_err_acc), 15);
        send(8'h08, 8'h08, 1'b0);
        for (int i = 0; i < 10 && !out_valid; i++) cycles(1);
        chk("clr_out_valid", longint'(out_valid), 1);
        clr_force = 1'b1;
        cycles(1);
        clr_force = 1'b0;
        chk("clr_err_cnt", longint'(err_cnt), 0);
        chk("clr_err_acc", longint'(err_acc), 0);
        chk("clr_err_max", longint'(err_max), 0);
        chk("clr_sat_cnt", longint'(x_err_cnt), 0);

        // Reset with two transactions in flight.
        send(8'h11, 8'h22, 1'b0);
        send(8'h33, 8'h44, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_sum", longint'(sum), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(6);
        chk("abort_no_output", longint'(out_valid), 0);

        // Random stream with gaps, backpressure and rare clears.
        rand_bp = 1'b1;
        rand_clr = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) cycles(1);
            send(int'($urandom_range(255)), int'($urandom_range(255)), bit'($urandom_range(1)));
        end
        rand_bp = 1'b0;
        rand_clr = 1'b0;
        drain();
        cycles(1);
        chk("final_err_acc", longint'(err_acc), longint'(m_acc16));
        chk("final_err_max", longint'(err_max), longint'(m_max));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/approx_add_pipe.md
APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 4..32).
REQ-002 SHALL have parameter K, default 4, number of approximated low bits (legal 1..WIDTH-1).
REQ-003 SHALL have parameter STAT_W, default 16, width of error-statistics counters.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 mode  input  1  0 = approximate, 1 = exact; sampled with the operands.
REQ-011 out_valid  output  1  sum valid.
REQ-012 out_ready  input  1  downstream accepts sum.
REQ-013 sum  output  WIDTH+1  result, MSB is carry-out.
REQ-014 stat_clr  input  1  synchronous clear of statistics.
REQ-015 err_cnt  output  STAT_W  count of approximate results differing from the exact sum.
REQ-016 err_acc  output  STAT_W  accumulated absolute error.
REQ-017 err_max  output  WIDTH+1  largest absolute error seen.

Function
REQ-018 Approximate sum SHALL be: sum[K-1:0] = a[K-1:0] | b[K-1:0]; cin_hi = a[K-1] & b[K-1]; sum[WIDTH:K] = a[WIDTH-1:K] + b[WIDTH-1:K] + cin_hi.
REQ-019 Exact sum SHALL be a + b, zero-extended to WIDTH+1 bits.
REQ-020 Pipeline SHALL have 2 stages: S1 registers the low part, cin_hi, upper operands, mode and the exact sum; S2 registers the upper addition and the final sum.
REQ-021 Latency SHALL be 2 cycles from an accepted input (in_valid & in_ready) to out_valid when out_ready stays high.
REQ-022 Throughput SHALL be one transaction per cycle with no bubbles when out_ready = 1.
REQ-023 in_ready SHALL equal !(S2 valid & !out_ready) | !S1 valid (pipeline advances unless the output is stalled and full); combinational from out_ready.
REQ-024 While out_valid = 1 and out_ready = 0, sum and out_valid SHALL hold stable, and S1 SHALL hold when S2 cannot drain.
REQ-025 Transactions SHALL leave in acceptance order; none dropped or duplicated.
REQ-026 Statistics SHALL update only on output handshake (out_valid & out_ready) and only for mode = 0 transactions.
REQ-027 On update: err = |exact - approx| (WIDTH+1 bits); err_cnt += (err != 0); err_acc += err; err_max = max(err_max, err).
REQ-028 err_cnt and err_acc SHALL saturate at all-ones and never wrap.
REQ-029 stat_clr SHALL zero all three statistics on the next edge; if it coincides with an update, the clear wins and the update is discarded.
REQ-030 Mode-1 transactions SHALL output the exact sum and leave the statistics unchanged.

Reset
REQ-031 rst_n = 0 SHALL immediately clear both stage-valid flags, out_valid = 0, sum = 0, err_cnt = 0, err_acc = 0, err_max = 0.
REQ-032 in_ready SHALL be 1 during and after reset.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight transactions; no output appears after deassertion without new input.
REQ-034 Deassertion SHALL take effect on the first clk edge after rst_n rises; no other initialisation cycles.

Verification (WIDTH=8, K=4)
REQ-035 a=0x0F, b=0x01, mode=0, out_ready=1 -> sum=0x00F after 2 cycles; err_cnt=1, err_acc=1, err_max=1.
REQ-036 a=0x08, b=0x08, mode=0 -> sum=0x018; err=8; err_max updates to 8; then a=0xFF, b=0x01, mode=1 -> sum=0x100, statistics unchanged.
REQ-037 Back-to-back stream of 4 pairs with out_ready=0 for cycles 3..5 -> in_ready falls when both stages are full, sums held stable, all 4 results delivered in order once out_ready=1.
REQ-038 STAT_W=4 and 20 erroneous mode-0 transactions -> err_cnt=0xF and err_acc=0xF saturated; stat_clr pulsed together with a handshake -> all statistics 0.
REQ-039 rst_n pulsed low with 2 transactions in flight -> out_valid=0 immediately, sum=0, no output appears after release until new input is accepted.
REQ-040 Random 10k mode-0 and mode-1 pairs checked against the REQ-018/019 reference model, with err_acc compared against the model sum.
